zrb_uart_rx_writer: RTL

UART receiver that feeds the write port of the `zrb_fifo` asynchronous FIFO. It runs in the FIFO write-clock domain and oversamples the asynchronous `rx` line on the `zrb_baud_generator` rx strobe. It majority-votes each bit and writes each valid 8N1 frame into the FIFO with a single-cycle `wr_en`. Frames with a bad stop bit are dropped with a frame-error pulse. Frames that arrive while the FIFO is full are dropped with an overrun pulse.

---
 rtl/zrb_uart_pkg.sv | 15 +
 rtl/zrb_uart_rx_writer_if.sv | 11 +
 rtl/zrb_bit_sync.sv | 19 +
 rtl/zrb_uart_rx_writer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/zrb_uart_pkg.sv
// zrb_uart_pkg: shared types and helpers for the zrb UART receive path.
package zrb_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    // Sample points as offsets from mid-bit tick M = OVERSAMPLE/2.
    localparam int SAMP_EARLY = -1;
    localparam int SAMP_MID   = 0;
    localparam int SAMP_LATE  = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/zrb_uart_rx_writer_if.sv
// zrb_uart_rx_writer_if: FIFO write port between the UART receiver and zrb_fifo.
interface zrb_uart_rx_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data;
    logic                  full;

    modport master (output wr_en, output data, input full);
    modport slave  (input wr_en, input data, output full);
endinterface

// File: rtl/zrb_bit_sync.sv
// zrb_bit_sync: single-bit multi-flop synchronizer with asynchronous reset.
module zrb_bit_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {STAGES{RESET_VAL}};
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/zrb_uart_rx_writer.sv
// zrb_uart_rx_writer: oversampling 8N1 UART receiver writing frames into zrb_fifo.
module zrb_uart_rx_writer
    import zrb_uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wr_clk,
    input  logic                 reset,
    input  logic                 baud_tick_i,
    input  logic                 rx_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    zrb_uart_rx_writer_if.master fifo
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_EARLY = TW'(M + SAMP_EARLY);
    localparam logic [TW-1:0] T_MID   = TW'(M + SAMP_MID);
    localparam logic [TW-1:0] T_LATE  = TW'(M + SAMP_LATE);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_WIDTH - 1);

    logic                  rx_s;
    state_e                state_q, state_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  s_early_q, s_early_d, s_mid_q, s_mid_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                  wr_en_q, wr_en_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                  dec, wrap, bit_v;

    zrb_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
        .clk (wr_clk),
        .rst (reset),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    assign dec   = tcnt_q == T_LATE;
    assign wrap  = tcnt_q == T_LAST;
    assign bit_v = maj3(s_early_q, s_mid_q, rx_s);

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        s_early_d = s_early_q;
        s_mid_d   = s_mid_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        if (baud_tick_i) begin
            tcnt_d    = wrap ? '0 : tcnt_q + 1'b1;
            s_early_d = (tcnt_q == T_EARLY) ? rx_s : s_early_q;
            s_mid_d   = (tcnt_q == T_MID) ? rx_s : s_mid_q;
            case (state_q)
                IDLE: begin
                    tcnt_d  = rx_s ? '0 : TW'(1);
                    state_d = rx_s ? IDLE : START;
                end
                START: begin
                    if (dec && bit_v) begin
                        state_d = IDLE;
                        tcnt_d  = '0;
                    end else if (wrap) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    if (dec) shreg_d = {bit_v, shreg_q[DATA_WIDTH-1:1]};
                    if (wrap) begin
                        bcnt_d  = (bcnt_q == B_LAST) ? '0 : bcnt_q + 1'b1;
                        state_d = (bcnt_q == B_LAST) ? STOP : DATA;
                    end
                end
                STOP: begin
                    if (dec) begin
                        tcnt_d  = '0;
                        state_d = bit_v ? IDLE : BREAK;
                        wr_en_d = bit_v & ~fifo.full;
                        ovr_d   = bit_v & fifo.full;
                        ferr_d  = ~bit_v;
                        data_d  = (bit_v & ~fifo.full) ? shreg_q : data_q;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a stuck-low line cannot relock.
                    tcnt_d  = '0;
                    state_d = rx_s ? IDLE : BREAK;
                end
                default: begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            s_early_q <= 1'b1;
            s_mid_q   <= 1'b1;
            shreg_q   <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            s_early_q <= s_early_d;
            s_mid_q   <= s_mid_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign fifo.wr_en  = wr_en_q;
    assign fifo.data   = data_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
endmodule
